// File: rtl/vec_add_run_ctrl.sv
// vec_add_run_ctrl: iterates a vector-add kernel, drains its result buffer and posts a completion word; VEC_ADD_RUN_CTRL_CHECKSUM_EN enables the checksum
module vec_add_run_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [15:0]       cfg_iters,
  input  logic [ADDR_W-1:0] cfg_len,
  output logic              kernel_start,
  input  logic              kernel_done,
  output logic [ADDR_W-1:0] z_rd_addr,
  input  logic [DATA_W-1:0] z_dout,
  output logic              wr_valid,
  input  logic              wr_almfull,
  output logic [63:0]       wr_data,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, START, WAIT_DONE, DRAIN, REPORT} state_t;
  state_t state, state_nx;
  logic [15:0] iters, iters_done;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W:0] dcnt, len_full;
  logic [31:0] wd, checksum;
  logic timeout_flag, wd_hit, last;
  assign len_full = {len == '0, len};
  assign wd_hit = TIMEOUT_CYCLES != 0 && wd == 32'(TIMEOUT_CYCLES - 1);
  assign last = dcnt == len_full;
  assign wr_data = {checksum, iters_done, 15'b0, timeout_flag};
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // next state and Moore outputs
  always_comb begin
    state_nx = state;
    kernel_start = state == START;
    busy = state != IDLE;
    cfg_ready = state == IDLE && !reset;
    case (state)
      IDLE:      state_nx = cfg_valid ? (cfg_iters == '0 ? REPORT : START) : IDLE;
      START:     state_nx = WAIT_DONE;
      WAIT_DONE: state_nx = kernel_done ? DRAIN : wd_hit ? REPORT : WAIT_DONE;
      DRAIN:     state_nx = !last ? DRAIN : (iters_done + 16'd1 == iters) ? REPORT : START;
      REPORT:    state_nx = wr_almfull ? REPORT : IDLE;
      default:   state_nx = IDLE;
    endcase
  end
  // run configuration, watchdog, drain addressing and completion pulse
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      iters <= '0;
      len <= '0;
      iters_done <= '0;
      timeout_flag <= 1'b0;
      wd <= '0;
      dcnt <= '0;
      z_rd_addr <= '0;
      wr_valid <= 1'b0;
    end else begin
      wr_valid <= state == REPORT && !wr_almfull;
      if (state == IDLE && cfg_valid) begin
        iters <= cfg_iters;
        len <= cfg_len;
        iters_done <= '0;
        timeout_flag <= 1'b0;
      end
      if (state == START) wd <= '0;
      if (state == WAIT_DONE) begin
        wd <= wd + 32'd1;
        if (kernel_done) begin
          z_rd_addr <= '0;
          dcnt <= '0;
        end else if (wd_hit) timeout_flag <= 1'b1;
      end
      if (state == DRAIN) begin
        dcnt <= dcnt + 1'b1;
        if (dcnt + 1'b1 < len_full) z_rd_addr <= z_rd_addr + 1'b1;
        if (last) iters_done <= iters_done + 16'd1;
      end
    end
`ifdef VEC_ADD_RUN_CTRL_CHECKSUM_EN
  // accumulate each word captured one cycle after its address was presented
  always_ff @(posedge clk or posedge reset)
    if (reset) checksum <= '0;
    else if (state == IDLE && cfg_valid) checksum <= '0;
    else if (state == DRAIN && dcnt != '0) checksum <= checksum + 32'(z_dout);
`else
  logic unused_z;
  assign checksum = '0;
  assign unused_z = ^z_dout;
`endif
endmodule

// File: tb/tb_vec_add_run_ctrl.sv
// tb_vec_add_run_ctrl: directed runs of vec_add_run_ctrl with a completion-word scoreboard
module tb_vec_add_run_ctrl;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int TO = 16;
  logic clk = 0, reset = 1, cfg_valid = 0, kernel_done = 0, wr_almfull = 0;
  logic [15:0] cfg_iters = 0;
  logic [ADDR_W-1:0] cfg_len = 0;
  logic [DATA_W-1:0] z_dout = 0;
  logic cfg_ready, kernel_start, wr_valid, busy;
  logic [ADDR_W-1:0] z_rd_addr;
  logic [63:0] wr_data;
  int checks = 0, errors = 0, ks_cnt = 0, wv_cnt = 0;
  logic [63:0] exp_q[$];

  vec_add_run_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_iters(cfg_iters), .cfg_len(cfg_len), .kernel_start(kernel_start),
    .kernel_done(kernel_done), .z_rd_addr(z_rd_addr), .z_dout(z_dout),
    .wr_valid(wr_valid), .wr_almfull(wr_almfull), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) z_dout <= DATA_W'(z_rd_addr) + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && kernel_start) ks_cnt++;
    if (!reset && wr_valid) begin
      wv_cnt++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL wr_valid_unexpected observed=1 expected=0");
      end
      if (exp_q.size() > 0) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        checks++;
        assert (wr_data === e) else begin
          errors++;
          $error("FAIL wr_data observed=%h expected=%h", wr_data, e);
        end
      end
    end
  end

  task automatic run(input int iters, input int len, input int dly, input bit hang, input int alm);
    int l, ks0, wv0;
    logic [31:0] cs;
    logic [63:0] e;
    l = (len == 0) ? (1 << ADDR_W) : len;
    cs = 0;
`ifdef VEC_ADD_RUN_CTRL_CHECKSUM_EN
    if (!hang) cs = 32'(iters * l * (l + 1) / 2);
`endif
    e = {cs, hang ? 16'd0 : 16'(iters), 15'b0, hang};
    exp_q.push_back(e);
    ks0 = ks_cnt;
    wv0 = wv_cnt;
    wr_almfull = alm > 0;
    @(negedge clk);
    chk("cfg_ready", cfg_ready, 1);
    cfg_valid = 1;
    cfg_iters = 16'(iters);
    cfg_len = ADDR_W'(len);
    @(negedge clk);
    cfg_valid = 0;
    for (int it = 0; it < iters; it++) begin
      chk("kernel_start", kernel_start, 1);
      if (hang) begin
        repeat (TO + 1) @(negedge clk);
        break;
      end
      cfg_valid = 1;
      cfg_iters = 16'd5;
      repeat (dly) @(negedge clk);
      cfg_valid = 0;
      kernel_done = 1;
      @(negedge clk);
      kernel_done = 0;
      for (int k = 0; k <= l; k++) begin
        chk("z_rd_addr", z_rd_addr, (k < l) ? k : l - 1);
        @(negedge clk);
      end
    end
    chk("report_busy", busy, 1);
    chk("report_wr_valid", wr_valid, 0);
    chk("report_wr_data", wr_data, e);
    repeat (alm) begin
      @(negedge clk);
      chk("almfull_hold_wr_valid", wr_valid, 0);
    end
    wr_almfull = 0;
    @(negedge clk);
    chk("wr_valid_pulse", wr_valid, 1);
    chk("idle_busy", busy, 0);
    @(negedge clk);
    chk("wr_valid_single", wr_valid, 0);
    chk("kernel_start_count", ks_cnt - ks0, hang ? 1 : iters);
    chk("wr_valid_count", wv_cnt - wv0, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_kernel_start", kernel_start, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_z_rd_addr", z_rd_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    reset = 0;
    @(negedge clk);
    chk("post_rst_cfg_ready", cfg_ready, 1);
    run(1, 4, 10, 0, 0);
    run(3, 2, 3, 0, 0);
    run(1, 3, 1, 1, 0);
    run(0, 5, 1, 0, 0);
    run(2, 1, 2, 0, 20);
    cfg_valid = 1;
    cfg_iters = 16'd1;
    cfg_len = ADDR_W'(8);
    @(negedge clk);
    cfg_valid = 0;
    chk("abort_kernel_start", kernel_start, 1);
    @(negedge clk);
    kernel_done = 1;
    @(negedge clk);
    kernel_done = 0;
    repeat (3) @(negedge clk);
    chk("abort_addr", z_rd_addr, 3);
    reset = 1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_z_rd_addr", z_rd_addr, 0);
    chk("abort_cfg_ready", cfg_ready, 0);
    chk("abort_wr_valid", wr_valid, 0);
    @(negedge clk);
    reset = 0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_wr_valid", wr_valid, 0);
    end
    chk("abort_idle_ready", cfg_ready, 1);
    run(1, 8, 1, 0, 0);
    run(1, 0, 2, 0, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
